mem_access_unit: RTL

- Parametrised, multi-cycle data-memory access unit for the MEM stage.
- Takes one load/store per instruction from the MEM stage and runs it on a Wishbone-classic data bus with ack handshake and wait states.
- Holds the pipeline with `stall_req_o` while an access is in flight.
- Adds width generality (32/64-bit), misalignment faults, bus timeout and flush/kill support.
- Its result replaces the single-cycle load/store path in the MEM stage.

---
 rtl/mem_access_unit.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: multi-cycle data-memory access unit for the MEM stage.
// It runs one load or store at a time on a Wishbone-classic data bus.
// The bus may insert wait states; the pipeline is held while the access is in flight.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_i, store_i, size_i,       access request from the MEM stage
//   unsigned_i, addr_i, wdata_i,  (the pipeline holds these stable while stall_req_o=1)
//   flush_i                       kills the access that is currently on the bus
//   stall_req_o                   pipeline hold request
//   done_o, rdata_o, bus_err_o    completion pulse, extended load data, timeout flag
//   adel_o, ades_o                misaligned load / store fault (combinational, in IDLE)
//   bus_*                         Wishbone-classic master interface
module mem_access_unit #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_i,
    input  logic                  store_i,
    input  logic [1:0]            size_i,
    input  logic                  unsigned_i,
    input  logic [ADDR_W-1:0]     addr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic                  flush_i,
    output logic                  stall_req_o,
    output logic                  done_o,
    output logic [DATA_W-1:0]     rdata_o,
    output logic                  adel_o,
    output logic                  ades_o,
    output logic                  bus_err_o,
    output logic                  bus_cyc_o,
    output logic                  bus_stb_o,
    output logic                  bus_we_o,
    output logic [ADDR_W-1:0]     bus_addr_o,
    output logic [DATA_W/8-1:0]   bus_sel_o,
    output logic [DATA_W-1:0]     bus_dat_o,
    input  logic [DATA_W-1:0]     bus_dat_i,
    input  logic                  bus_ack_i
);

    localparam int SEL_W = DATA_W / 8;
    localparam int LB    = $clog2(SEL_W);

    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

    // Keep the low 8n bits of an already lane-shifted word.
    // Then sign- or zero-extend them to DATA_W.
    function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] v,
                                                      input logic [1:0]        size,
                                                      input logic              uns);
        logic [DATA_W-1:0] keep;
        logic              sign;
        case (size)
            2'b00:   begin keep = DATA_W'(8'hFF);         sign = v[7];  end
            2'b01:   begin keep = DATA_W'(16'hFFFF);      sign = v[15]; end
            2'b10:   begin keep = DATA_W'(32'hFFFF_FFFF); sign = v[31]; end
            default: begin keep = '1;                     sign = 1'b0;  end
        endcase
        return (v & keep) | ((sign && !uns) ? ~keep : '0);
    endfunction

    state_t             state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               cyc_q, cyc_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [DATA_W-1:0]  dat_q, dat_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic [1:0]         size_q, size_d;
    logic               uns_q, uns_d;
    logic [LB-1:0]      lane_q, lane_d;

    logic [LB-1:0]      lane;
    logic [LB-1:0]      align_mask;
    logic [SEL_W-1:0]   sel_base;
    logic [DATA_W-1:0]  wdat_rep;
    logic [DATA_W-1:0]  rd_shift;
    logic               misalign;
    logic               accept;
    logic               fault;

    assign lane = addr_i[LB-1:0];

    // Request decode: alignment mask, lane enables and store-data replication
    always_comb begin
        case (size_i)
            2'b00: begin
                align_mask = '0;
                sel_base   = SEL_W'(1'b1);
                wdat_rep   = {SEL_W{wdata_i[7:0]}};
            end
            2'b01: begin
                align_mask = LB'(1);
                sel_base   = SEL_W'(2'b11);
                wdat_rep   = {(SEL_W/2){wdata_i[15:0]}};
            end
            2'b10: begin
                align_mask = LB'(3);
                sel_base   = SEL_W'(4'hF);
                wdat_rep   = {(SEL_W/4){wdata_i[31:0]}};
            end
            default: begin
                align_mask = '1;
                sel_base   = '1;
                wdat_rep   = wdata_i;
            end
        endcase
        // A dword on a 32-bit bus is a size fault regardless of address.
        misalign = (|(lane & align_mask)) || ((size_i == 2'b11) && (DATA_W != 64));
    end

    assign accept   = (state_q == IDLE) && req_i && !flush_i && !misalign;
    assign fault    = (state_q == IDLE) && req_i && !flush_i && misalign;
    assign rd_shift = bus_dat_i >> {lane_q, 3'b000};

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        cyc_d   = cyc_q;
        we_d    = we_q;
        addr_d  = addr_q;
        sel_d   = sel_q;
        dat_d   = dat_q;
        rdata_d = rdata_q;
        size_d  = size_q;
        uns_d   = uns_q;
        lane_d  = lane_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = BUS;
                    cyc_d   = 1'b1;
                    we_d    = store_i;
                    addr_d  = {addr_i[ADDR_W-1:LB], {LB{1'b0}}};
                    sel_d   = sel_base << lane;
                    dat_d   = wdat_rep;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    size_d  = size_i;
                    uns_d   = unsigned_i;
                    lane_d  = lane;
                end
            end
            BUS: begin
                // Flush beats a same-cycle ack; ack beats a same-cycle timeout.
                if (flush_i) begin
                    state_d = IDLE;
                    cyc_d   = 1'b0;
                end else if (bus_ack_i) begin
                    state_d = DONE;
                    cyc_d   = 1'b0;
                    if (!we_q) begin
                        rdata_d = load_extend(rd_shift, size_q, uns_q);
                    end
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    state_d = DONE;
                    cyc_d   = 1'b0;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
                err_d   = 1'b0;
            end
            default: begin
                state_d = IDLE;
                cyc_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            sel_q   <= '0;
            dat_q   <= '0;
            rdata_q <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            lane_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            sel_q   <= sel_d;
            dat_q   <= dat_d;
            rdata_q <= rdata_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            lane_q  <= lane_d;
        end
    end

    assign stall_req_o = accept || (state_q == BUS);
    assign done_o      = (state_q == DONE);
    assign bus_err_o   = (state_q == DONE) && err_q;
    assign adel_o      = fault && !store_i;
    assign ades_o      = fault && store_i;
    assign rdata_o     = rdata_q;
    assign bus_cyc_o   = cyc_q;
    assign bus_stb_o   = cyc_q;
    assign bus_we_o    = we_q;
    assign bus_addr_o  = addr_q;
    assign bus_sel_o   = sel_q;
    assign bus_dat_o   = dat_q;

endmodule
